// File: rtl/opcode_buffer.sv
// Fetches a WORD_WIDTH-bit opcode one byte at a time from a byte-wide memory port.
// The bytes are assembled big-endian in a shadow register and published to opcode only when complete.
module opcode_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] ip,
  input  logic                     startLoading,
  input  logic [7:0]               ramData,
  input  logic                     ramBusy,
  output logic                     busy,
  output logic [WORD_WIDTH-1:0]    opcode,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     request
);

  localparam int N  = WORD_WIDTH / 8;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DATA = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                   state_r,   state_s;
  logic [ADDRESS_WIDTH-1:0] base_r,    base_s;
  logic [KW-1:0]            k_r,       k_s;
  logic [WORD_WIDTH-1:0]    shadow_r,  shadow_s;
  logic                     busy_r,    busy_s;
  logic                     request_r, request_s;
  logic [ADDRESS_WIDTH-1:0] address_r, address_s;
  logic [WORD_WIDTH-1:0]    opcode_r,  opcode_s;

  // Next-state logic; request and address are prepared one cycle ahead so they leave the block registered.
  always_comb begin
    state_s   = state_r;
    base_s    = base_r;
    k_s       = k_r;
    shadow_s  = shadow_r;
    busy_s    = busy_r;
    request_s = 1'b0;
    address_s = address_r;
    opcode_s  = opcode_r;
    case (state_r)
      IDLE: begin
        if (startLoading) begin
          base_s    = ip;
          k_s       = {KW{1'b0}};
          busy_s    = 1'b1;
          request_s = 1'b1;
          address_s = ip;
          state_s   = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        state_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ramBusy) begin
          state_s = WAIT_DATA;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      WAIT_DATA: begin
        if (!ramBusy) begin
          for (int i = 0; i < N; i++) begin
            if (k_r == KW'(i)) begin
              shadow_s[WORD_WIDTH-1-8*i -: 8] = ramData;
            end else begin
              shadow_s[WORD_WIDTH-1-8*i -: 8] = shadow_r[WORD_WIDTH-1-8*i -: 8];
            end
          end
          if (k_r == KW'(N - 1)) begin
            state_s = DONE;
          end else begin
            k_s       = k_r + KW'(1);
            request_s = 1'b1;
            address_s = base_r + ADDRESS_WIDTH'(k_s);
            state_s   = REQ;
          end
        end else begin
          state_s = WAIT_DATA;
        end
      end
      DONE: begin
        opcode_s = shadow_r;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      base_r    <= {ADDRESS_WIDTH{1'b0}};
      k_r       <= {KW{1'b0}};
      shadow_r  <= {WORD_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      request_r <= 1'b0;
      address_r <= {ADDRESS_WIDTH{1'b0}};
      opcode_r  <= {WORD_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      base_r    <= base_s;
      k_r       <= k_s;
      shadow_r  <= shadow_s;
      busy_r    <= busy_s;
      request_r <= request_s;
      address_r <= address_s;
      opcode_r  <= opcode_s;
    end
  end

  assign busy    = busy_r;
  assign request = request_r;
  assign address = address_r;
  assign opcode  = opcode_r;

endmodule

// File: tb/tb_opcode_buffer.sv
// Self-checking bench for opcode_buffer: a byte-memory responder with adjustable ack delay,
// and a reference that assembles the expected opcode directly from the memory contents.
module tb_opcode_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ip = 32'd0;
  logic        startLoading = 1'b0;
  logic [7:0]  ramData = 8'd0;
  logic        ramBusy = 1'b0;
  logic        busy;
  logic [31:0] opcode;
  logic [31:0] address;
  logic        request;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addr_q [$];
  int          ack_delay = 1;
  int          deliveries = 0;
  int          pulse_err = 0;

  opcode_buffer #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ip(ip), .startLoading(startLoading),
    .ramData(ramData), .ramBusy(ramBusy), .busy(busy), .opcode(opcode),
    .address(address), .request(request)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Expected opcode: four consecutive bytes from base, first byte most significant, addresses wrap.
  function automatic logic [31:0] ref_opcode(input logic [31:0] base);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r = {r[23:0], rd(base + 32'(i))};
    return r;
  endfunction

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) mem[base + 32'(i)] = 8'($urandom);
  endtask

  // Memory responder: samples address on request, raises ramBusy after ack_delay cycles, holds it two cycles.
  initial begin
    int mstate = 0;
    int cnt = 0;
    logic [31:0] maddr = 32'd0;
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (request && prev_req) pulse_err++;
      prev_req = request;
      if (reset) begin
        mstate = 0;
        ramBusy = 1'b0;
      end else begin
        case (mstate)
          0: if (request) begin
            maddr = address;
            addr_q.push_back(address);
            cnt = ack_delay;
            mstate = 1;
          end
          1: begin
            cnt--;
            if (cnt == 0) begin ramBusy = 1'b1; cnt = 2; mstate = 2; end
          end
          2: begin
            cnt--;
            if (cnt == 0) begin
              ramBusy = 1'b0;
              ramData = rd(maddr);
              deliveries++;
              mstate = 0;
            end
          end
          default: mstate = 0;
        endcase
      end
    end
  end

  task automatic wait_busy_fall(output bit ok, output int changes);
    logic [31:0] op0;
    bit prev;
    op0 = opcode;
    prev = busy;
    ok = 1'b0;
    changes = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (busy && opcode !== op0) changes++;
      if (prev && !busy) begin ok = 1'b1; break; end
      prev = busy;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if (request !== 1'b0) $display("FAIL reset_request got=%b want=0", request); else passed++;
    total++; if (address !== 32'd0) $display("FAIL reset_address got=%h want=0", address); else passed++;
    total++; if (opcode !== 32'd0) $display("FAIL reset_opcode got=%h want=0", opcode); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok; int ch;
    mem[32'd0] = 8'h3C; mem[32'd1] = 8'h08; mem[32'd2] = 8'h00; mem[32'd3] = 8'h01;
    addr_q.delete(); pulse_err = 0; ack_delay = 1;
    ip = 32'd0; startLoading = 1'b1;
    wait_busy_fall(ok, ch);
    total++; if (!ok) $display("FAIL basic_timeout got=timeout want=done"); else passed++;
    total++; if (opcode !== 32'h3C080001) $display("FAIL basic_opcode got=%h want=3c080001", opcode); else passed++;
    total++; if (addr_q.size() !== 4) $display("FAIL basic_addr_count got=%0d want=4", addr_q.size()); else passed++;
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      total++; if (addr_q[i] !== 32'(i)) $display("FAIL basic_addr%0d got=%h want=%h", i, addr_q[i], i); else passed++;
    end
    total++; if (pulse_err !== 0) $display("FAIL basic_pulse got=%0d want=0", pulse_err); else passed++;
  endtask

  // Continues straight from test_basic: startLoading is still high and busy has just fallen.
  task automatic test_back_to_back;
    bit ok; int ch;
    mem[32'd4] = 8'hAA; mem[32'd5] = 8'hBB; mem[32'd6] = 8'hCC; mem[32'd7] = 8'hDD;
    ip = 32'd4;
    addr_q.delete();
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL b2b_gap got=%b want=1", busy); else passed++;
    wait_busy_fall(ok, ch);
    startLoading = 1'b0;
    total++; if (!ok) $display("FAIL b2b_timeout got=timeout want=done"); else passed++;
    total++; if (ch !== 0) $display("FAIL b2b_hold got=%0d want=0", ch); else passed++;
    total++; if (opcode !== 32'hAABBCCDD) $display("FAIL b2b_opcode got=%h want=aabbccdd", opcode); else passed++;
    total++; if (addr_q.size() !== 4 || addr_q[0] !== 32'd4)
      $display("FAIL b2b_addr got=%0d want=4", addr_q.size()); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap;
    bit ok; int ch;
    logic [31:0] b;
    b = 32'hFFFFFFFE;
    fill(b);
    addr_q.delete();
    ip = b; startLoading = 1'b1;
    @(negedge clk);
    startLoading = 1'b0;
    wait_busy_fall(ok, ch);
    total++; if (!ok) $display("FAIL wrap_timeout got=timeout want=done"); else passed++;
    total++; if (opcode !== ref_opcode(b)) $display("FAIL wrap_opcode got=%h want=%h", opcode, ref_opcode(b)); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= addr_q.size() || addr_q[i] !== b + 32'(i))
        $display("FAIL wrap_addr%0d got=%h want=%h", i, (i < addr_q.size()) ? addr_q[i] : 32'hX, b + 32'(i));
      else passed++;
    end
  endtask

  task automatic test_slow;
    bit ok; int ch;
    logic [31:0] b;
    b = $urandom;
    fill(b);
    ack_delay = 5; pulse_err = 0;
    ip = b; startLoading = 1'b1;
    @(negedge clk);
    startLoading = 1'b0;
    wait_busy_fall(ok, ch);
    total++; if (!ok) $display("FAIL slow_timeout got=timeout want=done"); else passed++;
    total++; if (opcode !== ref_opcode(b)) $display("FAIL slow_opcode got=%h want=%h", opcode, ref_opcode(b)); else passed++;
    total++; if (pulse_err !== 0) $display("FAIL slow_pulse got=%0d want=0", pulse_err); else passed++;
    ack_delay = 1;
  endtask

  task automatic test_ip_change;
    bit ok; int ch;
    logic [31:0] a, b;
    a = $urandom; b = a + 32'h100;
    fill(a); fill(b);
    ip = a; startLoading = 1'b1;
    @(negedge clk);
    startLoading = 1'b0;
    repeat (3) @(negedge clk);
    ip = b;
    wait_busy_fall(ok, ch);
    total++; if (!ok) $display("FAIL ipchg_timeout got=timeout want=done"); else passed++;
    total++; if (opcode !== ref_opcode(a)) $display("FAIL ipchg_opcode got=%h want=%h", opcode, ref_opcode(a)); else passed++;
  endtask

  task automatic test_random;
    bit ok; int ch;
    logic [31:0] b;
    for (int n = 0; n < 6; n++) begin
      b = $urandom;
      fill(b);
      ack_delay = $urandom_range(1, 4);
      addr_q.delete();
      ip = b; startLoading = 1'b1;
      @(negedge clk);
      startLoading = 1'b0;
      wait_busy_fall(ok, ch);
      total++;
      if (!ok || opcode !== ref_opcode(b) || addr_q.size() !== 4 || addr_q[3] !== b + 32'd3)
        $display("FAIL random%0d got=%h want=%h", n, opcode, ref_opcode(b));
      else passed++;
    end
    ack_delay = 1;
  endtask

  task automatic test_reset_mid;
    bit ok; int ch; int d0;
    logic [31:0] b;
    b = $urandom;
    fill(b);
    d0 = deliveries;
    ip = b; startLoading = 1'b1;
    @(negedge clk);
    startLoading = 1'b0;
    for (int c = 0; c < 200 && deliveries < d0 + 2; c++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || request !== 1'b0)
      $display("FAIL midrst_ctrl got=%b%b want=00", busy, request); else passed++;
    total++; if (address !== 32'd0) $display("FAIL midrst_address got=%h want=0", address); else passed++;
    total++; if (opcode !== 32'd0) $display("FAIL midrst_opcode got=%h want=0", opcode); else passed++;
    reset = 1'b0;
    @(negedge clk);
    b = $urandom;
    fill(b);
    ip = b; startLoading = 1'b1;
    @(negedge clk);
    startLoading = 1'b0;
    wait_busy_fall(ok, ch);
    total++; if (!ok || opcode !== ref_opcode(b))
      $display("FAIL midrst_refetch got=%h want=%h", opcode, ref_opcode(b)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_slow();
    test_ip_change();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
